// File: rtl/freq_meter_if.sv
// Measurement bus for freq_meter: the signal under test, control inputs and the result outputs.
// FREQ_METER_PERIOD_EN adds the period result. GATE_W/CNT_W must match the attached freq_meter.
interface freq_meter_if #(
    parameter int GATE_W = 32,
    parameter int CNT_W  = 32
);
    logic              sig_in;
    logic [GATE_W-1:0] gate_len;
    logic              start;
    logic              continuous;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  edge_count;
    logic              overflow;
`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0]  period;
`endif

    modport master (
        output sig_in, gate_len, start, continuous,
`ifdef FREQ_METER_PERIOD_EN
        input  period,
`endif
        input  busy, done, edge_count, overflow
    );

    modport slave (
        input  sig_in, gate_len, start, continuous,
`ifdef FREQ_METER_PERIOD_EN
        output period,
`endif
        output busy, done, edge_count, overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over gate_len clk_in cycles.
// Optional FREQ_METER_PERIOD_EN also reports the clk_in cycles between the last two counted rises.
//
// state    | meaning
// IDLE     | waiting for start with a non-zero gate_len
// MEASURE  | window open, rises accumulated, gate counter running down
// DONE     | one-cycle result strobe, re-arms when continuous is set
module freq_meter #(
    parameter int GATE_W      = 32,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         i_clk_in,
    input  logic         i_reset,
    freq_meter_if.slave  io_bus
);
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]        r_state;
    logic [SYNC_N-1:0] r_sync;
    logic              r_hist;
    logic [GATE_W-1:0] r_gate_ctr;
    logic [CNT_W-1:0]  r_acc;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_edge_count;
    logic              r_overflow;

    logic              w_rise;
    logic              w_acc_full;
    logic [CNT_W-1:0]  w_acc_nxt;
    logic              w_ovf_nxt;
    logic              w_open;
    logic              w_last;

    // Synchroniser and edge history run in every state so the first window cycle sees valid history.
    always_ff @(posedge i_clk_in) begin
        if (!i_reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], io_bus.sig_in};
            r_hist <= r_sync[SYNC_N-1];
        end
    end

    assign w_rise     = r_sync[SYNC_N-1] & ~r_hist;
    assign w_acc_full = &r_acc;
    assign w_acc_nxt  = (w_rise && !w_acc_full) ? r_acc + CNT_W'(1) : r_acc;
    // Overflow flags a rise that could not be counted because the accumulator was already full.
    assign w_ovf_nxt  = r_ovf | (w_rise & w_acc_full);

    assign w_open = (io_bus.gate_len != '0) &&
                    (((r_state == ST_IDLE) && io_bus.start) ||
                     ((r_state == ST_DONE) && io_bus.continuous));
    assign w_last = (r_state == ST_MEASURE) && (r_gate_ctr == GATE_W'(1));

    always_ff @(posedge i_clk_in) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_gate_ctr   <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_edge_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_open) begin
                        r_state    <= ST_MEASURE;
                        r_gate_ctr <= io_bus.gate_len;
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    r_acc      <= w_acc_nxt;
                    r_ovf      <= w_ovf_nxt;
                    r_gate_ctr <= r_gate_ctr - GATE_W'(1);
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_edge_count <= w_acc_nxt;
                        r_overflow   <= w_ovf_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.busy       = (r_state != ST_IDLE);
    assign io_bus.done       = (r_state == ST_DONE);
    assign io_bus.edge_count = r_edge_count;
    assign io_bus.overflow   = r_overflow;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] r_per_ctr;
    logic [CNT_W-1:0] r_per_last;
    logic [CNT_W-1:0] r_period;
    logic             w_per_take;

    // A rise only closes a period when an earlier rise in this window was already counted.
    assign w_per_take = w_rise && (r_acc != '0);

    always_ff @(posedge i_clk_in) begin
        if (!i_reset) begin
            r_per_ctr  <= '0;
            r_per_last <= '0;
            r_period   <= '0;
        end else if (w_open) begin
            r_per_ctr  <= '0;
            r_per_last <= '0;
        end else if (r_state == ST_MEASURE) begin
            if (w_rise) begin
                r_per_ctr <= CNT_W'(1);
            end else if (!(&r_per_ctr)) begin
                r_per_ctr <= r_per_ctr + CNT_W'(1);
            end
            if (w_per_take) begin
                r_per_last <= r_per_ctr;
            end
            if (w_last) begin
                r_period <= w_per_take ? r_per_ctr : r_per_last;
            end
        end
    end

    assign io_bus.period = r_period;
`endif
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Gated frequency meter that sits directly downstream of the clock divider. It takes the divided clock (or any slow signal) as an asynchronous data input and counts its rising edges over a programmable window of clk_in cycles. Results are reported with a one-cycle done strobe. The bench and firmware use it to check divider ratio on-chip (fast/slow ratio = gate_len / edge_count).

Parameters:
GATE_W, 32, width of gate_len and the internal gate counter
CNT_W, 32, width of edge_count and the edge accumulator
SYNC_STAGES, 2, synchronizer flop count on sig_in (minimum 2)

Ports:
clk_in  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
sig_in  input  1  signal under measurement, asynchronous to clk_in (e.g. divider clk_out)
gate_len  input  GATE_W  window length in clk_in cycles; sampled on accepted start
start  input  1  request a measurement; honoured only in IDLE
continuous  input  1  when 1, re-arm automatically after each DONE; sampled in DONE
busy  output  1  1 in MEASURE and DONE
done  output  1  single-cycle strobe; result registers valid from this cycle
edge_count  output  CNT_W  rising edges counted in last completed window
overflow  output  1  last window saturated the accumulator

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; busy=0, done=0, edge_count=0, overflow=0; synchronizer and edge-history flops=0; gate counter and accumulator=0.
- sig_in passes SYNC_STAGES flops, then one history flop; rise = sync_out & ~hist. Pipeline runs in every state, so history is valid when a window opens. Latency sig_in edge -> rise: SYNC_STAGES+1 cycles.
- A high sig_in at reset release yields one rise within SYNC_STAGES+1 cycles. Start must not be issued inside that interval; if it is, that rise is counted (accepted behaviour).
- IDLE: start==1 && gate_len!=0 -> MEASURE; gate_ctr<=gate_len, acc<=0, ovf<=0. start with gate_len==0 is ignored (stay IDLE, no done).
- MEASURE: each cycle, if rise then acc<=acc+1, saturating at all-ones; saturation sets ovf. gate_ctr decrements. When gate_ctr==1, that cycle's rise is still counted and the state moves to DONE. Exactly gate_len cycles are sampled.
- DONE (one cycle): done=1; edge_count<=final acc; overflow<=ovf; both are registered on entry so they are visible while done=1. Rises during DONE are not counted (one dead cycle).
- DONE exit: continuous==1 -> MEASURE with gate_len re-sampled, acc/ovf cleared; otherwise -> IDLE. In continuous mode done period = gate_len+1 cycles.
- start while busy: ignored, no queuing. gate_len changes mid-window have no effect.
- edge_count/overflow hold the previous result until the next DONE.
- Reset mid-window: aborts immediately, no done, all outputs return to reset values.
- Width rule: gate_len up to 2^GATE_W-1. Accumulator never wraps.

Optional Feature:
FREQ_METER_PERIOD_EN
- Defined: adds output period [CNT_W] and a CNT_W cycle counter. period = clk_in cycles between the last two counted rises in the window, latched at DONE with edge_count. Fewer than 2 rises -> period=0. The counter saturates at all-ones. Reset value is 0.
- Undefined: port, counter and logic absent; all other behaviour identical.

Test Plan:
- sig_in square wave period 10 clk_in cycles, gate_len=1000, start pulse -> single done 1001..1004 cycles after start (SYNC_STAGES=2); edge_count=100, overflow=0; with FREQ_METER_PERIOD_EN, period=10.
- sig_in held 0, gate_len=1 -> done 2 cycles after start, edge_count=0. Then start with gate_len=0 -> no done, busy stays 0.
- CNT_W=4, sig_in period 2, gate_len=100 -> edge_count=15, overflow=1. Next window with period 20, gate_len=100 -> edge_count=5, overflow=0.
- continuous=1, gate_len=500, sig_in period 50 -> done every 501 cycles, each edge_count=10 (±1 from dead cycle). Drop continuous -> returns to IDLE after next done.
- Extra start pulses at cycles 10 and 200 of a 1000-cycle window -> ignored; exactly one done.
- reset=0 for one cycle at cycle 300 of a window -> no done; busy=0, edge_count=0 next cycle. Fresh start -> correct result.
